dmaif_rdreq_route: RTL
======================

Name: dmaif_rdreq_route

Overview:
- Request-direction counterpart of the DMAIF read-response merge.
- Takes one DMA read-request stream from a client and steers each request to mcif or cvif by ram_type.
- The response path OR-merges mcif and cvif data, so this block guarantees only one target has responses in flight at any time.
- Per-target outstanding-beat counters gate every target switch.

Parameters:
- ADDR_W, 64, request address width.
- SIZE_W, 15, size field width; response beats per request = size+1.
- CNT_W, 16, outstanding-beat counter width per target.

Ports:
- nvdla_core_clk  in  1  core clock.
- nvdla_core_rst  in  1  reset; synchronous, active-high. One clock domain.
- dmaif_rd_req_pd  in  ADDR_W+SIZE_W  request payload: [ADDR_W-1:0] addr, [ADDR_W+SIZE_W-1:ADDR_W] size.
- dmaif_rd_req_ram_type  in  1  1=mcif, 0=cvif; qualified by pvld.
- dmaif_rd_req_pvld  in  1  client request valid.
- dmaif_rd_req_prdy  out  1  client request ready; registered.
- mcif_rd_req_pd  out  ADDR_W+SIZE_W  payload to mcif, passed unmodified.
- mcif_rd_req_valid  out  1
- mcif_rd_req_ready  in  1
- cvif_rd_req_pd  out  ADDR_W+SIZE_W  payload to cvif, passed unmodified.
- cvif_rd_req_valid  out  1
- cvif_rd_req_ready  in  1
- mcif_rd_rsp_mon  in  1  one pulse per mcif response beat accepted (valid&ready at the response-merge input).
- cvif_rd_rsp_mon  in  1  same, for cvif.
- dmaif_rd_req_idle  out  1  skid empty, both output registers empty, both counters zero.
- dmaif_rd_rsp_err  out  1  sticky; set on monitor pulse while the matching counter is 0.

Behaviour:
- Stage 1: 2-entry skid buffer holding {ram_type, pd}.
  - prdy is registered; it is 1 when at least one entry is free after the current cycle.
  - Full throughput when downstream does not stall.
- Stage 2: one valid-hold output register per target.
  - valid stays high and pd stays stable until ready.
  - No combinational path from mcif/cvif ready to prdy.
- Latency: accepted at edge N → target valid visible after edge N+1 at the earliest. Steady state is 1 request/cycle.
- FSM owner ∈ {IDLE, MC, CV}. Head of skid targets T; it issues into T's output register only when all hold:
  - owner==IDLE or owner==T;
  - T's output register is empty, or is being accepted this cycle;
  - cnt_T + size + 1 ≤ 2^CNT_W−1 (no counter overflow).
- If any condition fails, the head stalls. No reordering: a request behind the head never bypasses it.
- Transitions:
  - IDLE→T on the first issue to T.
  - T→IDLE when cnt_T==0, T's output register is empty, and no issue to T happens that cycle.
  - MC↔CV never directly; always via IDLE. At least one IDLE cycle between the last MC response and the first CV issue.
- Counter rules:
  - On issue: cnt_T += size+1, zero-extended to CNT_W.
  - On mon_T pulse: cnt_T −= 1.
  - Issue and pulse in the same cycle: cnt_T + size + 1 − 1.
  - Pulse with cnt_T==0: cnt_T stays 0, dmaif_rd_rsp_err←1; cleared only by reset.
- Monitor pulse for the non-owner target with count 0 also sets err. It is otherwise ignored.
- Reset (any cycle, including mid-transfer), registered values:
  - all valids 0, skid emptied, prdy 0;
  - counters 0, owner IDLE, err 0, idle 1.
- First cycle after reset deasserts: prdy=1.
- In-flight requests and responses are dropped; their recovery belongs to the system-level reset.
- Payload bits never altered; ram_type is not forwarded.

Test Plan:
- Single mcif request, addr=0x1000, size=3, ready=1 → mcif_valid one cycle later with pd unchanged; cnt_MC=4; after 4 mon pulses, owner=IDLE and idle=1.
- Back-to-back 8 mcif requests, size=0, ready=1 → 8 consecutive mcif_valid cycles; prdy never drops; cvif_valid stays 0.
- mcif size=1, then cvif size=0; hold the mcif monitor for 10 cycles → cvif_valid stays 0 until 2 mcif mon pulses plus 1 IDLE cycle; then cvif issues with pd exact.
- mcif_ready=0 for 6 cycles with a 5-request burst → mcif_valid and pd held stable; prdy drops after 2 skid entries plus 1 output entry; all 5 delivered in order once ready=1.
- Counter limit: CNT_W=4, request size=15 (16 beats) → stalls, no overflow. Size=14 then size=0 → second stalls until a mon pulse frees space.
- Error and reset: cvif mon pulse at cnt_CV=0 → err=1 sticky. Assert reset mid-burst → all valids 0, counters 0, err 0, idle 1 next cycle.

Source files
------------

// File: rtl/dmaif_rdreq_route.sv
// DMA read-request router: steers one client request stream to mcif or cvif,
// allowing only one target to have responses outstanding at a time.
module dmaif_rdreq_route #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned SIZE_W = 15,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                     nvdla_core_clk,
    input  logic                     nvdla_core_rst,
    input  logic [ADDR_W+SIZE_W-1:0] dmaif_rd_req_pd,
    input  logic                     dmaif_rd_req_ram_type,
    input  logic                     dmaif_rd_req_pvld,
    output logic                     dmaif_rd_req_prdy,
    output logic [ADDR_W+SIZE_W-1:0] mcif_rd_req_pd,
    output logic                     mcif_rd_req_valid,
    input  logic                     mcif_rd_req_ready,
    output logic [ADDR_W+SIZE_W-1:0] cvif_rd_req_pd,
    output logic                     cvif_rd_req_valid,
    input  logic                     cvif_rd_req_ready,
    input  logic                     mcif_rd_rsp_mon,
    input  logic                     cvif_rd_rsp_mon,
    output logic                     dmaif_rd_req_idle,
    output logic                     dmaif_rd_rsp_err
);

    localparam int unsigned PD_W  = ADDR_W + SIZE_W;
    localparam int unsigned ENT_W = PD_W + 1;
    localparam int unsigned SUM_W = ((CNT_W > SIZE_W) ? CNT_W : SIZE_W) + 2;
    localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_MC   = 2'd1,
        OWN_CV   = 2'd2
    } owner_e;

    logic [ENT_W-1:0]  skid_q [2];
    logic              skid_wr_q;
    logic              skid_rd_q;
    logic [1:0]        skid_cnt_q, skid_cnt_d;
    logic              prdy_q, prdy_d;
    logic              mc_vld_q, mc_vld_d;
    logic              cv_vld_q, cv_vld_d;
    logic [PD_W-1:0]   mc_pd_q, mc_pd_d;
    logic [PD_W-1:0]   cv_pd_q, cv_pd_d;
    logic [CNT_W-1:0]  mc_cnt_q, mc_cnt_d;
    logic [CNT_W-1:0]  cv_cnt_q, cv_cnt_d;
    owner_e            owner_q, owner_d;
    logic              err_q, err_d;
    logic              idle_q, idle_d;

    logic [ENT_W-1:0]  head;
    logic              head_vld;
    logic              head_mc;
    logic [SIZE_W-1:0] head_size;
    logic [SUM_W-1:0]  mc_sum, cv_sum;
    logic              req_acc, mc_issue, cv_issue, pop, mc_dec, cv_dec;

    // Head-of-skid decode and issue qualification (owner, slot free, no counter overflow)
    assign head      = skid_q[skid_rd_q];
    assign head_vld  = (skid_cnt_q != 2'd0);
    assign head_mc   = head[PD_W];
    assign head_size = head[PD_W-1:ADDR_W];
    assign req_acc   = dmaif_rd_req_pvld && prdy_q;

    assign mc_sum = SUM_W'(mc_cnt_q) + SUM_W'(head_size) + SUM_W'(1);
    assign cv_sum = SUM_W'(cv_cnt_q) + SUM_W'(head_size) + SUM_W'(1);

    assign mc_issue = head_vld && head_mc && (owner_q != OWN_CV) &&
                      (!mc_vld_q || mcif_rd_req_ready) && (mc_sum <= CNT_MAX);
    assign cv_issue = head_vld && !head_mc && (owner_q != OWN_MC) &&
                      (!cv_vld_q || cvif_rd_req_ready) && (cv_sum <= CNT_MAX);
    assign pop      = mc_issue || cv_issue;

    // A monitor pulse with nothing outstanding is an error, never an underflow
    assign mc_dec = mcif_rd_rsp_mon && (mc_cnt_q != '0);
    assign cv_dec = cvif_rd_rsp_mon && (cv_cnt_q != '0);

    always_comb begin
        skid_cnt_d = skid_cnt_q + 2'(req_acc) - 2'(pop);
        prdy_d     = (skid_cnt_d != 2'd2);

        mc_vld_d = mc_vld_q;
        mc_pd_d  = mc_pd_q;
        if (mc_issue) begin
            mc_vld_d = 1'b1;
            mc_pd_d  = head[PD_W-1:0];
        end else if (mcif_rd_req_ready) begin
            mc_vld_d = 1'b0;
        end

        cv_vld_d = cv_vld_q;
        cv_pd_d  = cv_pd_q;
        if (cv_issue) begin
            cv_vld_d = 1'b1;
            cv_pd_d  = head[PD_W-1:0];
        end else if (cvif_rd_req_ready) begin
            cv_vld_d = 1'b0;
        end

        mc_cnt_d = mc_cnt_q;
        if (mc_issue) mc_cnt_d = mc_sum[CNT_W-1:0];
        if (mc_dec)   mc_cnt_d = mc_cnt_d - CNT_W'(1);

        cv_cnt_d = cv_cnt_q;
        if (cv_issue) cv_cnt_d = cv_sum[CNT_W-1:0];
        if (cv_dec)   cv_cnt_d = cv_cnt_d - CNT_W'(1);

        err_d = err_q || (mcif_rd_rsp_mon && (mc_cnt_q == '0))
                      || (cvif_rd_rsp_mon && (cv_cnt_q == '0));

        // Ownership returns to IDLE only once the target is fully drained
        owner_d = owner_q;
        case (owner_q)
            OWN_IDLE: begin
                if (mc_issue)      owner_d = OWN_MC;
                else if (cv_issue) owner_d = OWN_CV;
            end
            OWN_MC: if ((mc_cnt_q == '0) && !mc_vld_q && !mc_issue) owner_d = OWN_IDLE;
            OWN_CV: if ((cv_cnt_q == '0) && !cv_vld_q && !cv_issue) owner_d = OWN_IDLE;
            default: owner_d = OWN_IDLE;
        endcase

        idle_d = (skid_cnt_d == 2'd0) && !mc_vld_d && !cv_vld_d &&
                 (mc_cnt_d == '0) && (cv_cnt_d == '0);
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            skid_q[0]  <= '0;
            skid_q[1]  <= '0;
            skid_wr_q  <= 1'b0;
            skid_rd_q  <= 1'b0;
            skid_cnt_q <= 2'd0;
            prdy_q     <= 1'b0;
            mc_vld_q   <= 1'b0;
            cv_vld_q   <= 1'b0;
            mc_pd_q    <= '0;
            cv_pd_q    <= '0;
            mc_cnt_q   <= '0;
            cv_cnt_q   <= '0;
            owner_q    <= OWN_IDLE;
            err_q      <= 1'b0;
            idle_q     <= 1'b1;
        end else begin
            if (req_acc) skid_q[skid_wr_q] <= {dmaif_rd_req_ram_type, dmaif_rd_req_pd};
            skid_wr_q  <= skid_wr_q ^ req_acc;
            skid_rd_q  <= skid_rd_q ^ pop;
            skid_cnt_q <= skid_cnt_d;
            prdy_q     <= prdy_d;
            mc_vld_q   <= mc_vld_d;
            cv_vld_q   <= cv_vld_d;
            mc_pd_q    <= mc_pd_d;
            cv_pd_q    <= cv_pd_d;
            mc_cnt_q   <= mc_cnt_d;
            cv_cnt_q   <= cv_cnt_d;
            owner_q    <= owner_d;
            err_q      <= err_d;
            idle_q     <= idle_d;
        end
    end

    assign dmaif_rd_req_prdy = prdy_q;
    assign mcif_rd_req_valid = mc_vld_q;
    assign mcif_rd_req_pd    = mc_pd_q;
    assign cvif_rd_req_valid = cv_vld_q;
    assign cvif_rd_req_pd    = cv_pd_q;
    assign dmaif_rd_req_idle = idle_q;
    assign dmaif_rd_rsp_err  = err_q;

endmodule
